// File: rtl/counter_pair_checker.sv
// Step checker for a pair of 8-bit counter streams: flags per-sample step
// mismatches, counts samples/errors and signals done when cnt2 hits TARGET2.
module counter_pair_checker #(
  parameter int unsigned STEP1   = 1,
  parameter int unsigned STEP2   = 1,
  parameter int unsigned TARGET2 = 208,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cnt_valid,
  input  logic [7:0]    cnt1_in,
  input  logic [7:0]    cnt2_in,
  output logic          err1,
  output logic          err2,
  output logic          err_sticky,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] sample_count,
  output logic          done,
  output logic          busy
);

  localparam logic [7:0] STEP1_B   = 8'(STEP1);
  localparam logic [7:0] STEP2_B   = 8'(STEP2);
  localparam logic [7:0] TARGET2_B = 8'(TARGET2);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  state_t        state_q;
  logic [7:0]    prev1_q, prev2_q;
  logic          err1_q, err2_q, err_sticky_q, done_q, busy_q;
  logic [CW-1:0] err_count_q, sample_count_q;

  logic [7:0]    exp1_d, exp2_d;
  logic          mis1_d, mis2_d, hit_d;
  logic [CW-1:0] smp_inc_d, err_inc_d;

  // Expected values wrap naturally in 8 bits, so 255->0 is a legal step.
  always_comb begin
    exp1_d    = prev1_q + STEP1_B;
    exp2_d    = prev2_q + STEP2_B;
    mis1_d    = (cnt1_in != exp1_d);
    mis2_d    = (cnt2_in != exp2_d);
    hit_d     = (cnt2_in == TARGET2_B);
    smp_inc_d = (sample_count_q == '1) ? sample_count_q : sample_count_q + CW'(1);
    err_inc_d = (err_count_q == '1) ? err_count_q : err_count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      prev1_q        <= '0;
      prev2_q        <= '0;
      err1_q         <= 1'b0;
      err2_q         <= 1'b0;
      err_sticky_q   <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      err_count_q    <= '0;
      sample_count_q <= '0;
    end else begin
      err1_q <= 1'b0;
      err2_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cnt_valid) begin
            prev1_q <= cnt1_in;
            prev2_q <= cnt2_in;
            if (hit_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= TRACK;
              busy_q  <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (cnt_valid) begin
            err1_q         <= mis1_d;
            err2_q         <= mis2_d;
            err_sticky_q   <= err_sticky_q | mis1_d | mis2_d;
            // Track actual inputs so a single glitch yields a single error.
            prev1_q        <= cnt1_in;
            prev2_q        <= cnt2_in;
            sample_count_q <= smp_inc_d;
            if (mis1_d || mis2_d) err_count_q <= err_inc_d;
            if (hit_d) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign err1         = err1_q;
  assign err2         = err2_q;
  assign err_sticky   = err_sticky_q;
  assign err_count    = err_count_q;
  assign sample_count = sample_count_q;
  assign done         = done_q;
  assign busy         = busy_q;

endmodule

// File: doc/counter_pair_checker.md
Name: counter_pair_checker

Overview:
- Downstream consumer of the dual 8-bit counter block. Samples cnt1/cnt2 each valid cycle and checks each stream advances by its configured step, modulo 256.
- Flags step errors, counts checked samples and errors, and raises done when cnt2 reaches a target value.
- Replaces hand-written $display/$finish checking in benches and top-level integration with synthesizable self-check status.

Parameters:
- STEP1, 1, expected per-sample increment of cnt1 (mod 256).
- STEP2, 1, expected per-sample increment of cnt2 (mod 256).
- TARGET2, 208, cnt2 value that terminates checking.
- CW, 16, width of sample and error counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cnt_valid  input  1  sample strobe; counters' outputs are checked only when high.
- cnt1_in  input  8  cnt1 value from counter block.
- cnt2_in  input  8  cnt2 value from counter block.
- err1  output  1  one-cycle pulse: cnt1 step mismatch on the previous valid sample.
- err2  output  1  one-cycle pulse: cnt2 step mismatch.
- err_sticky  output  1  set on any err1/err2, cleared only by rst.
- err_count  output  CW  number of mismatching samples, saturating; a sample with both mismatches counts once.
- sample_count  output  CW  valid samples accepted in TRACK, saturating at all-ones.
- done  output  1  high from the cycle after TARGET2 is seen until rst.
- busy  output  1  high in TRACK.

Behaviour:
- Reset (async assert, state update on clk edge after deassert): state=IDLE; prev1=prev2=0; err1=err2=err_sticky=done=busy=0; err_count=sample_count=0.
- States:
  - IDLE: on cnt_valid, capture prev1<=cnt1_in, prev2<=cnt2_in and go to TRACK. This first sample is a baseline: no check, not counted. If cnt2_in==TARGET2 in this sample, go directly to DONE.
  - TRACK: busy=1. On each cnt_valid:
    - exp1=(prev1+STEP1) mod 256, exp2=(prev2+STEP2) mod 256, computed in 8 bits so wrap 255->0 is legal with STEP=1.
    - err1<=(cnt1_in!=exp1); err2<=(cnt2_in!=exp2).
    - Update prev1/prev2 with the actual inputs, not the expected values, so one glitch gives one error, not a cascade.
    - sample_count+1; err_count+1 if either mismatch. Both counters saturate.
    - If cnt2_in==TARGET2, go to DONE. The comparison and count for that sample still apply.
  - cnt_valid low in TRACK: no state change; err1/err2 return to 0; prev values held.
  - DONE: done=1, busy=0. Inputs ignored; counters, err_sticky and prev values frozen; err1/err2 0. Exit only via rst.
- Latency: all outputs registered. Status reflects a sample one cycle after the clk edge that captured it. done asserts exactly one cycle after the TARGET2 sample edge.
- err_sticky is set in the same cycle err1 or err2 asserts.
- rst asserted mid-TRACK clears everything immediately (async). After release, the next valid sample is a fresh baseline, so the counters' own reset value never appears as a step error.
- No combinational path from inputs to outputs.

Test Plan:
1. Counter stream 0,1,2,…,208 with cnt_valid=1, STEP1=STEP2=1 -> done rises one cycle after the 208 sample; sample_count=208; err_count=0; err_sticky=0.
2. cnt1 stream 254,255,0,1 (cnt2 stepping normally) -> no err1; wrap accepted; sample_count=3.
3. cnt2 stream 10,11,13,14 -> single err2 pulse on the 13 sample only; err_count=1; err_sticky=1 and held; no error on the 14 sample.
4. Same-cycle cnt1 and cnt2 mismatch -> err1 and err2 both pulse; err_count increments by 1.
5. rst asserted at sample_count=50 with err_sticky=1, released, stream restarts at 0 -> all outputs 0 during rst; first post-reset sample is a baseline only; no spurious error.
6. cnt_valid toggled 1,0,0,1 with cnt2 values 5,x,x,6 -> no error; sample_count increments only on valid samples; after done, changing inputs leaves all counters frozen.
